param_seq_alu: RTL

- Parametrised, registered successor to the 4-bit combinational ALU.
- WIDTH-bit operands; MIPS-style op encoding with op[2] = binv.
- Adds a valid/ready handshake, registered flags, and a multi-cycle shift-add unsigned multiply.
- Sits between the register-file read stage and write-back of the datapath.

---
 rtl/param_seq_alu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/param_seq_alu.sv
// Registered WIDTH-bit ALU with a valid/ready handshake and registered flags.
// MUL is a multi-cycle shift-add multiply; every other op completes in one cycle.
module param_seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_c_msb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_cout;
  logic             w_alu_ovf;

  assign in_ready  = (r_state == S_IDLE) |
                     ((r_state == S_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_is_mul  = (op == OP_MUL);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_MUL);
  assign result    = r_result;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign zero      = (r_result == '0);

  // Shared adder: op[2] inverts b and injects the carry-in.
  assign w_b_eff = op[2] ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} +
                   {{WIDTH{1'b0}}, op[2]};
  assign w_c_msb = a[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_sum[WIDTH-1];
  assign w_ovf   = w_c_msb ^ w_sum[WIDTH];

  assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_last = (r_cnt == LAST_CNT);

  always_comb begin
    w_alu_res  = '0;
    w_alu_cout = 1'b0;
    w_alu_ovf  = 1'b0;
    case (op)
      OP_AND: w_alu_res = a & b;
      OP_OR:  w_alu_res = a | b;
      OP_NOR: w_alu_res = ~(a | b);
      OP_ADD, OP_SUB: begin
        w_alu_res  = w_sum[WIDTH-1:0];
        w_alu_cout = w_sum[WIDTH];
        w_alu_ovf  = w_ovf;
      end
      OP_SLT: begin
        w_alu_res  = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
        w_alu_cout = w_sum[WIDTH];
        w_alu_ovf  = w_ovf;
      end
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_state_nxt = w_is_mul ? S_MUL : S_DONE;
      end
      S_MUL: begin
        if (w_mul_last)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_accept)
          w_state_nxt = w_is_mul ? S_MUL : S_DONE;
        else if (out_ready)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_acc    <= '0;
        r_mcand  <= a;
        r_mplier <= b;
        r_cnt    <= '0;
      end else begin
        r_result <= w_alu_res;
        r_cout   <= w_alu_cout;
        r_ovf    <= w_alu_ovf;
      end
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_mul_last) begin
        r_result <= w_acc_nxt;
        r_cout   <= 1'b0;
        r_ovf    <= 1'b0;
      end
    end
  end

endmodule
